// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter.
package mem_arb_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_t;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_LDR = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between core and loader requests.
// ARB_ROUND_ROBIN_EN: ties alternate based on the previous grant;
// otherwise the loader always wins a tie.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic ldr_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic last_gnt,
`endif
    output logic gnt_c,
    output logic any_c
);

    // Pick a winner; only meaningful when any_c is high
    always_comb begin
        any_c = cpu_req | ldr_req;
        gnt_c = GNT_CPU;
        if (cpu_req && ldr_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            gnt_c = (last_gnt == GNT_CPU) ? GNT_LDR : GNT_CPU;
`else
            gnt_c = GNT_LDR;
`endif
        end else if (ldr_req) begin
            gnt_c = GNT_LDR;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (core / program loader) arbiter in front of a fixed-latency memory.
// Optional macro ARB_ROUND_ROBIN_EN switches tie-breaking to round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW      = 10,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_ack,
    output logic [DW-1:0] ldr_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               gnt_q, gnt_d;
    logic               mem_en_d, mem_we_d;
    logic [AW-1:0]      mem_addr_d;
    logic [DW-1:0]      mem_wdata_d;
    logic               cpu_ack_d, ldr_ack_d;
    logic [DW-1:0]      cpu_rdata_d, ldr_rdata_d;
    logic               gnt_c, any_c;
`ifdef ARB_ROUND_ROBIN_EN
    logic               last_gnt_q, last_gnt_d;
`endif

    mem_arb_pick u_pick (
        .cpu_req  (cpu_req),
        .ldr_req  (ldr_req),
`ifdef ARB_ROUND_ROBIN_EN
        .last_gnt (last_gnt_q),
`endif
        .gnt_c    (gnt_c),
        .any_c    (any_c)
    );

    assign cpu_stall = cpu_req & ~cpu_ack;

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        mem_en_d    = mem_en;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        cpu_ack_d   = 1'b0;
        ldr_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata;
        ldr_rdata_d = ldr_rdata;
`ifdef ARB_ROUND_ROBIN_EN
        last_gnt_d  = last_gnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_c) begin
                    gnt_d       = gnt_c;
                    cnt_d       = CNT_W'(MEM_LAT - 1);
                    mem_en_d    = 1'b1;
                    mem_we_d    = (gnt_c == GNT_LDR) ? ldr_we    : cpu_we;
                    mem_addr_d  = (gnt_c == GNT_LDR) ? ldr_addr  : cpu_addr;
                    mem_wdata_d = (gnt_c == GNT_LDR) ? ldr_wdata : cpu_wdata;
`ifdef ARB_ROUND_ROBIN_EN
                    last_gnt_d  = gnt_c;
`endif
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (gnt_q == GNT_LDR) begin
                    ldr_rdata_d = mem_rdata;
                    ldr_ack_d   = 1'b1;
                end else begin
                    cpu_rdata_d = mem_rdata;
                    cpu_ack_d   = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            gnt_q      <= GNT_CPU;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_ack    <= 1'b0;
            ldr_ack    <= 1'b0;
            cpu_rdata  <= '0;
            ldr_rdata  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_gnt_q <= GNT_CPU;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            mem_en     <= mem_en_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            cpu_ack    <= cpu_ack_d;
            ldr_ack    <= ldr_ack_d;
            cpu_rdata  <= cpu_rdata_d;
            ldr_rdata  <= ldr_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_gnt_q <= last_gnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (MEM_LAT=2).
module tb_mem_arbiter;

    localparam int unsigned AW  = 10;
    localparam int unsigned DW  = 32;
    localparam int unsigned LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack, cpu_stall;
    logic [DW-1:0] cpu_rdata;
    logic          ldr_req = 1'b0, ldr_we = 1'b0;
    logic [AW-1:0] ldr_addr = '0;
    logic [DW-1:0] ldr_wdata = '0;
    logic          ldr_ack;
    logic [DW-1:0] ldr_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;

    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .ldr_req   (ldr_req),
        .ldr_we    (ldr_we),
        .ldr_addr  (ldr_addr),
        .ldr_wdata (ldr_wdata),
        .ldr_ack   (ldr_ack),
        .ldr_rdata (ldr_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for an ack on the selected port
    task automatic wait_ack(input bit use_ldr, output int unsigned at, output bit seen);
        seen = 1'b0;
        at   = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (use_ldr ? ldr_ack : cpu_ack) begin
                seen = 1'b1;
                at   = cyc;
            end
        end
    endtask

    initial begin
        int unsigned t_l, t_c;
        bit          seen;
        int          acks;
        logic        exp_ldr;

        // Asynchronous reset before any clock edge
        #1 rst = 1'b0;
        #2;
        check("rst_mem_en", mem_en, 0);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_ldr_ack", ldr_ack, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        step();
        step();
        @(negedge clk) rst = 1'b1;
        step();

        // Single core read, req kept high through ack
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h004;
        mem_rdata = 32'h2002_0005;
        step();                                 // edge N
        check("rd_en_n1", mem_en, 1);
        check("rd_addr", mem_addr, 10'h004);
        check("rd_we", mem_we, 0);
        check("rd_stall_n", cpu_stall, 1);
        step();                                 // N+1
        check("rd_en_n2", mem_en, 1);
        check("rd_stall_n1", cpu_stall, 1);
        step();                                 // N+2
        check("rd_en_off", mem_en, 0);
        check("rd_noack_n2", cpu_ack, 0);
        check("rd_stall_n2", cpu_stall, 1);
        step();                                 // N+3
        check("rd_ack", cpu_ack, 1);
        check("rd_rdata", cpu_rdata, 32'h2002_0005);
        check("rd_stall_ack", cpu_stall, 0);
        step();                                 // N+4: held req restarts
        check("rd_ack_pulse", cpu_ack, 0);
        check("rd_b2b_en", mem_en, 1);
        cpu_req = 1'b0;
        wait_ack(1'b0, t_c, seen);
        check("rd_b2b_ack_seen", seen, 1);
        step();

        // Simultaneous requests
        mem_rdata = 32'h1111_0000;
        ldr_addr = 10'h010; ldr_we = 1'b0;
        cpu_addr = 10'h020;
        ldr_req = 1'b1; cpu_req = 1'b1;
        step();
        check("tie_first_addr", mem_addr, 10'h010);
        wait_ack(1'b1, t_l, seen);
        check("tie_ldr_ack_seen", seen, 1);
        check("tie_cpu_not_yet", cpu_ack, 0);
        ldr_req = 1'b0;
        wait_ack(1'b0, t_c, seen);
        check("tie_cpu_ack_seen", seen, 1);
        check("tie_ack_gap", t_c - t_l, LAT + 2);
        cpu_req = 1'b0;
        step();

        // Both held for four transactions
        ldr_req = 1'b1; cpu_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                step();
                if (cpu_ack || ldr_ack) seen = 1'b1;
            end
            check("hold_ack_seen", seen, 1);
`ifdef ARB_ROUND_ROBIN_EN
            exp_ldr = (k % 2 == 0);
`else
            exp_ldr = 1'b1;
`endif
            check("hold_grant", ldr_ack, exp_ldr);
        end
        ldr_req = 1'b0; cpu_req = 1'b0;
        step();
        step();

        // Loader write at top address; inputs changed mid-access
        mem_rdata = 32'h5555_AAAA;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 10'h3FF; ldr_wdata = 32'hDEAD_BEEF;
        step();
        check("wr_en", mem_en, 1);
        check("wr_we", mem_we, 1);
        check("wr_addr", mem_addr, 10'h3FF);
        check("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
        ldr_addr = 10'h001; ldr_wdata = 32'h0; ldr_we = 1'b0; ldr_req = 1'b0;
        step();
        check("wr_we_hold", mem_we, 1);
        check("wr_addr_hold", mem_addr, 10'h3FF);
        check("wr_wdata_hold", mem_wdata, 32'hDEAD_BEEF);
        step();
        check("wr_en_off", mem_en, 0);
        check("wr_we_off", mem_we, 0);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ldr_ack) acks++;
        end
        check("wr_ack_once", acks, 1);
        check("wr_ldr_rdata", ldr_rdata, 32'h5555_AAAA);
        check("wr_cpu_rdata_hold", cpu_rdata, 32'h1111_0000);

        // Reset during the first access cycle
        mem_rdata = 32'h3333_4444;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h055;
        step();
        check("ra_en_pre", mem_en, 1);
        #2 rst = 1'b0;
        #1;
        check("ra_en_async", mem_en, 0);
        check("ra_addr_async", mem_addr, 0);
        step();
        step();
        check("ra_no_ack", cpu_ack, 0);
        check("ra_cpu_rdata", cpu_rdata, 0);
        check("ra_ldr_rdata", ldr_rdata, 0);
        @(negedge clk) rst = 1'b1;
        step();
        check("ra_fresh_en", mem_en, 1);
        check("ra_fresh_addr", mem_addr, 10'h055);
        step();
        check("ra_fresh_en2", mem_en, 1);
        step();
        check("ra_fresh_noack", cpu_ack, 0);
        cpu_req = 1'b0;
        step();
        check("ra_fresh_ack", cpu_ack, 1);
        check("ra_fresh_rdata", cpu_rdata, 32'h3333_4444);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
